ifetch_stage: RTL

Instruction fetch stage between the program counter and the IF/ID boundary. Issues one instruction-memory request at a time for the current PC and holds at most one returned instruction in a skid buffer. Loads the IF/ID pipeline register and drives the PC's `pc_write` enable, so the PC advances only when a fetch retires or a branch flush redirects it. Handles decode stalls (read-after-load hazard) and EX-stage branch flushes, including squashing a response that is still in flight.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch_skid.sv | 64 ++++++
 rtl/ifetch_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM state encoding (IDLE, WAIT, HOLD, DROP)
//   NOP_INSTR     : bubble instruction, addi x0,x0,0
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no request outstanding
        WAIT = 2'd1,  // one request outstanding
        HOLD = 2'd2,  // response parked in skid buffer, decode stalled
        DROP = 2'd3   // waiting for a squashed response
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : ifetch_pkg

// File: rtl/ifetch_skid.sv
// ifetch_skid: one-entry {pc, instr} holding register for a fetched
// instruction that decode cannot accept yet.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture pc_in/instr_in and mark the entry full
//   clear      : empty the entry (wins over load)
//   pc_in      : PC of the instruction being captured
//   instr_in   : instruction being captured
//   full       : entry holds a valid instruction
//   pc_out     : buffered PC
//   instr_out  : buffered instruction
import ifetch_pkg::*;

module ifetch_skid #(
    parameter int unsigned            PC_width    = 32,
    parameter int unsigned            INSTR_width = 32,
    parameter logic [INSTR_width-1:0] NOP         = NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   clear,
    input  logic [PC_width-1:0]    pc_in,
    input  logic [INSTR_width-1:0] instr_in,
    output logic                   full,
    output logic [PC_width-1:0]    pc_out,
    output logic [INSTR_width-1:0] instr_out
);

    logic                   full_q,  full_d;
    logic [PC_width-1:0]    pc_q,    pc_d;
    logic [INSTR_width-1:0] instr_q, instr_d;

    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            full_d  = 1'b0;
            pc_d    = '0;
            instr_d = NOP;
        end else if (load) begin
            full_d  = 1'b1;
            pc_d    = pc_in;
            instr_d = instr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full      = full_q;
    assign pc_out    = pc_q;
    assign instr_out = instr_q;

endmodule : ifetch_skid

// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch stage between the PC and the IF/ID register.
// Issues one memory request at a time, parks a response in a skid buffer
// while decode is stalled, and squashes in-flight responses on a flush.
//   clk, rst_n      : clock, asynchronous active-low reset
//   pc_in           : current PC
//   pc_write        : PC load enable (retire or flush)
//   imem_req_valid  : fetch request valid
//   imem_req_addr   : fetch address (pc_in)
//   imem_req_ready  : memory accepts the request
//   imem_rsp_valid  : response valid (single-cycle pulse)
//   imem_rsp_data   : fetched instruction
//   id_stall        : decode cannot accept a new instruction
//   flush           : taken branch/jump in EX, pc_in already shows target
//   id_valid/id_pc/id_instr : registered IF/ID contents
import ifetch_pkg::*;

module ifetch_stage #(
    parameter int unsigned            PC_width    = 32,
    parameter int unsigned            INSTR_width = 32,
    parameter logic [INSTR_width-1:0] NOP         = NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PC_width-1:0]    pc_in,
    output logic                   pc_write,
    output logic                   imem_req_valid,
    output logic [PC_width-1:0]    imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_width-1:0] imem_rsp_data,
    input  logic                   id_stall,
    input  logic                   flush,
    output logic                   id_valid,
    output logic [PC_width-1:0]    id_pc,
    output logic [INSTR_width-1:0] id_instr
);

    fetch_state_e state_q, state_d;

    logic [PC_width-1:0]    req_pc_q,   req_pc_d;
    logic                   id_valid_q, id_valid_d;
    logic [PC_width-1:0]    id_pc_q,    id_pc_d;
    logic [INSTR_width-1:0] id_instr_q, id_instr_d;

    logic                   skid_load;
    logic                   skid_clear;
    logic                   skid_full;
    logic [PC_width-1:0]    skid_pc;
    logic [INSTR_width-1:0] skid_instr;

    logic                   req_valid;
    logic                   retire;
    logic [PC_width-1:0]    retire_pc;
    logic [INSTR_width-1:0] retire_instr;

    ifetch_skid #(
        .PC_width    (PC_width),
        .INSTR_width (INSTR_width),
        .NOP         (NOP)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .clear     (skid_clear),
        .pc_in     (req_pc_q),
        .instr_in  (imem_rsp_data),
        .full      (skid_full),
        .pc_out    (skid_pc),
        .instr_out (skid_instr)
    );

    // Next-state, retirement and skid control; flush overrides everything.
    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        req_valid    = 1'b0;
        retire       = 1'b0;
        retire_pc    = req_pc_q;
        retire_instr = imem_rsp_data;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_valid = ~flush;
                if (req_valid && imem_req_ready) begin
                    state_d  = WAIT;
                    req_pc_d = pc_in;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = imem_rsp_valid ? IDLE : DROP;
                end else if (imem_rsp_valid) begin
                    if (id_stall) begin
                        state_d   = HOLD;
                        skid_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        retire  = 1'b1;
                    end
                end
            end
            HOLD: begin
                retire_pc    = skid_pc;
                retire_instr = skid_instr;
                if (flush) begin
                    state_d    = IDLE;
                    skid_clear = 1'b1;
                end else if (!id_stall) begin
                    state_d    = IDLE;
                    retire     = skid_full;
                    skid_clear = 1'b1;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // IF/ID register: flush > stall-hold > retire > bubble.
    always_comb begin
        id_valid_d = 1'b0;
        id_pc_d    = '0;
        id_instr_d = NOP;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (id_stall) begin
            id_valid_d = id_valid_q;
            id_pc_d    = id_pc_q;
            id_instr_d = id_instr_q;
        end else if (retire) begin
            id_valid_d = 1'b1;
            id_pc_d    = retire_pc;
            id_instr_d = retire_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_pc_q   <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    // Combinational outputs are gated by rst_n so they drop during reset
    // without waiting for a clock edge.
    assign imem_req_valid = rst_n & req_valid;
    assign imem_req_addr  = pc_in;
    assign pc_write       = rst_n & (retire | flush);

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;

endmodule : ifetch_stage
